// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: layer type codes, FSM state
// encoding and the bit layout of one layer-table entry.
package layer_seq_pkg;

  localparam int ENTRY_W  = 17;
  localparam int TYPE_LSB = 15;
  localparam int TYPE_W   = 2;
  localparam int MAT_LSB  = 10;
  localparam int MAT_W    = 5;
  localparam int MAT2_LSB = 0;
  localparam int MAT2_W   = 10;

  typedef enum logic [1:0] {
    LT_CONV  = 2'd0,
    LT_MAXP  = 2'd1,
    LT_DENSE = 2'd2,
    LT_SKIP  = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // Engine enable vector {dense, maxp, conv} for a layer type; skip maps to none.
  function automatic logic [2:0] type_to_en(input layer_type_e t);
    case (t)
      LT_CONV:  type_to_en = 3'b001;
      LT_MAXP:  type_to_en = 3'b010;
      LT_DENSE: type_to_en = 3'b100;
      default:  type_to_en = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Engine-side bundle of the layer sequencer: per-engine enable/STOP pairs plus
// the geometry and RAM base addresses presented to whichever engine is active.
interface layer_sequencer_if #(
  parameter int SIZE_address_pix = 13
);
  logic                        conv_en;
  logic                        maxp_en;
  logic                        dense_en;
  logic                        conv_stop;
  logic                        maxp_stop;
  logic                        dense_stop;
  logic [SIZE_address_pix-1:0] memstartp;
  logic [SIZE_address_pix-1:0] memstartzap;
  logic [4:0]                  matrix;
  logic [9:0]                  matrix2;

  modport master (
    output conv_en, maxp_en, dense_en, memstartp, memstartzap, matrix, matrix2,
    input  conv_stop, maxp_stop, dense_stop
  );

  modport slave (
    input  conv_en, maxp_en, dense_en, memstartp, memstartzap, matrix, matrix2,
    output conv_stop, maxp_stop, dense_stop
  );
endinterface

// File: rtl/layer_sequencer_table.sv
// layer_table: programmable layer descriptor store, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module layer_table
  import layer_seq_pkg::*;
#(
  parameter int   NUM_LAYERS = 8,
  localparam int  LW         = $clog2(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [LW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [NUM_LAYERS];

  // Configuration write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the layer table, enabling one engine per layer and
// ping-ponging the source/destination pixel buffers between layers.
// Optional feature macro: LAYER_SEQ_TIMEOUT_EN (per-layer RUN watchdog that
// sets err and ends the pass); without it err is tied low.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int  SIZE_address_pix = 13,
  parameter int  NUM_LAYERS       = 8,
  parameter int  BUF_A_BASE       = 0,
  parameter int  BUF_B_BASE       = 4096,
  parameter int  TIMEOUT_CYCLES   = 1 << 20,
  localparam int LW               = $clog2(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [LW-1:0]      cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic [LW:0]        num_layers,
  input  logic               start,
  layer_sequencer_if.master  eng,
  output logic [LW-1:0]      layer_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  seq_state_e                  state_q, state_d;
  layer_type_e                 type_q;
  logic [LW-1:0]               idx_q, last_q;
  logic                        busy_q;
  logic [SIZE_address_pix-1:0] memstartp_q, memstartzap_q;
  logic [MAT_W-1:0]            matrix_q;
  logic [MAT2_W-1:0]           matrix2_q;
  logic [ENTRY_W-1:0]          entry;
  logic [2:0]                  en_vec;
  logic                        active_stop;
  logic [LW:0]                 n_eff;

  // The table is frozen while a pass is in flight.
  layer_table #(.NUM_LAYERS(NUM_LAYERS)) u_table (
    .clk   (clk),
    .we    (cfg_we & ~busy_q),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_q),
    .rdata (entry)
  );

  // Out-of-range layer counts run the whole table.
  assign n_eff = (num_layers == '0 || num_layers > (LW+1)'(NUM_LAYERS))
               ? (LW+1)'(NUM_LAYERS) : num_layers;

  assign en_vec      = (state_q == ST_RUN) ? type_to_en(type_q) : 3'b000;
  assign active_stop = |(en_vec & {eng.dense_stop, eng.maxp_stop, eng.conv_stop});

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] run_cnt_q;
  logic          timeout_hit;
  logic          err_q;

  assign timeout_hit = (run_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in RUN for the current layer; restarts in LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n)                run_cnt_q <= '0;
    else if (state_q == ST_LOAD) run_cnt_q <= '0;
    else if (state_q == ST_RUN)  run_cnt_q <= run_cnt_q + 1'b1;
  end

  // Sticky timeout flag, cleared when a new pass is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state_q == ST_IDLE && start)
      err_q <= 1'b0;
    else if (state_q == ST_RUN && timeout_hit && !active_stop && type_q != LT_SKIP)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN: begin
        if (type_q == LT_SKIP || active_stop) state_d = ST_DRAIN;
`ifdef LAYER_SEQ_TIMEOUT_EN
        else if (timeout_hit)                 state_d = ST_DONE;
`endif
      end
      ST_DRAIN: state_d = ST_NEXT;
      ST_NEXT:  state_d = (idx_q == last_q) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pass bookkeeping: layer index, geometry latch and buffer ping-pong.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      last_q        <= '0;
      busy_q        <= 1'b0;
      type_q        <= LT_CONV;
      matrix_q      <= '0;
      matrix2_q     <= '0;
      memstartp_q   <= SIZE_address_pix'(BUF_A_BASE);
      memstartzap_q <= SIZE_address_pix'(BUF_B_BASE);
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          idx_q         <= '0;
          last_q        <= LW'(n_eff - 1'b1);
          busy_q        <= 1'b1;
          memstartp_q   <= SIZE_address_pix'(BUF_A_BASE);
          memstartzap_q <= SIZE_address_pix'(BUF_B_BASE);
        end
        ST_LOAD: begin
          type_q    <= layer_type_e'(entry[TYPE_LSB +: TYPE_W]);
          matrix_q  <= entry[MAT_LSB +: MAT_W];
          matrix2_q <= entry[MAT2_LSB +: MAT2_W];
        end
        ST_NEXT: begin
          memstartp_q   <= memstartzap_q;
          memstartzap_q <= memstartp_q;
          if (idx_q != last_q) idx_q <= idx_q + 1'b1;
        end
        ST_DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign eng.conv_en     = en_vec[0];
  assign eng.maxp_en     = en_vec[1];
  assign eng.dense_en    = en_vec[2];
  assign eng.memstartp   = memstartp_q;
  assign eng.memstartzap = memstartzap_q;
  assign eng.matrix      = matrix_q;
  assign eng.matrix2     = matrix2_q;
  assign layer_idx       = idx_q;
  assign busy            = busy_q;
  assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: table-driven passes with a scoreboard of
// expected engine activations, plus hand-written reset/disturb/timeout cases.
module tb_layer_sequencer;

  localparam int          AW    = 13;
  localparam logic [12:0] BUF_A = 13'd0;
  localparam logic [12:0] BUF_B = 13'd4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [16:0] cfg_data;
  logic [3:0]  num_layers;
  logic        start;
  logic [2:0]  layer_idx;
  logic        busy, done, err;

  layer_sequencer_if #(.SIZE_address_pix(AW)) eif ();

  layer_sequencer #(
    .SIZE_address_pix(AW), .NUM_LAYERS(8), .BUF_A_BASE(0), .BUF_B_BASE(4096),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_layers(num_layers), .start(start), .eng(eif),
    .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [2:0] en_v;
  assign en_v = {eif.dense_en, eif.maxp_en, eif.conv_en};

  typedef struct {
    logic [2:0]  en;
    logic [12:0] p;
    logic [12:0] z;
    logic [4:0]  m;
    logic [9:0]  m2;
    logic [2:0]  idx;
    int          gap;
  } exp_t;

  typedef struct {
    logic [3:0]  nl;
    bit          disturb;
    int          exp_layers;
    logic [12:0] exp_final;
  } vec_t;

  exp_t        sbq[$];
  logic [16:0] tbl [8];
  vec_t        vecs [7];
  int          total = 0;
  int          bad   = 0;
  int          stop_delay = 10;
  int          exp_len    = 10;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench model of the expected engine activations for one pass.
  task automatic push_expected(input int n);
    int skips;
    bit first;
    exp_t e;
    skips = 0;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (tbl[i][16:15] == 2'd3) begin
        skips++;
      end else begin
        e.en  = 3'b001 << tbl[i][16:15];
        e.p   = (i % 2 == 0) ? BUF_A : BUF_B;
        e.z   = (i % 2 == 0) ? BUF_B : BUF_A;
        e.m   = tbl[i][14:10];
        e.m2  = tbl[i][9:0];
        e.idx = 3'(i);
        e.gap = first ? 0 : 3 + 4 * skips;
        sbq.push_back(e);
        first = 1'b0;
        skips = 0;
      end
    end
  endtask

  // Engine responder: active engine raises STOP after stop_delay enabled
  // cycles; the other stops are held high during conv runs as noise.
  initial begin
    int cnt;
    cnt = 0;
    eif.conv_stop = 1'b0; eif.maxp_stop = 1'b0; eif.dense_stop = 1'b0;
    forever begin
      @(negedge clk);
      if (en_v == 3'b000) begin
        cnt = 0;
        eif.conv_stop = 1'b0; eif.maxp_stop = 1'b0; eif.dense_stop = 1'b0;
      end else begin
        cnt++;
        eif.conv_stop  = en_v[0] && cnt == stop_delay;
        eif.maxp_stop  = (en_v[1] && cnt == stop_delay) || en_v[0];
        eif.dense_stop = (en_v[2] && cnt == stop_delay) || en_v[0];
      end
    end
  end

  // Monitor: pops the scoreboard on every enable rising edge and checks
  // run length and the idle gap between consecutive engine runs.
  initial begin
    logic [2:0] prev_en;
    bit   have_prev;
    int   gap, rl;
    exp_t e;
    prev_en = 3'b000; have_prev = 1'b0; gap = 0; rl = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) chk("en_onehot", 32'($countones(en_v) <= 1), 32'd1);
      if (en_v != 3'b000 && prev_en == 3'b000) begin
        if (sbq.size() == 0) begin
          chk("unexpected_en", 32'(en_v), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("en_select", 32'(en_v), 32'(e.en));
          chk("memstartp", 32'(eif.memstartp), 32'(e.p));
          chk("memstartzap", 32'(eif.memstartzap), 32'(e.z));
          chk("matrix", 32'(eif.matrix), 32'(e.m));
          chk("matrix2", 32'(eif.matrix2), 32'(e.m2));
          chk("layer_idx", 32'(layer_idx), 32'(e.idx));
          if (have_prev && e.gap != 0) chk("en_gap", 32'(gap), 32'(e.gap));
        end
        rl = 1;
      end else if (en_v != 3'b000) begin
        rl++;
      end else if (prev_en != 3'b000) begin
        if (rst_n === 1'b1) chk("run_len", 32'(rl), 32'(exp_len));
        have_prev = 1'b1;
        gap = 1;
      end else begin
        gap++;
      end
      if (busy !== 1'b1) have_prev = 1'b0;
      prev_en = en_v;
    end
  end

  task automatic run_pass(input logic [3:0] nl, input int n, input logic [12:0] fin,
                          input bit disturb);
    bit seen;
    push_expected(n);
    @(negedge clk);
    num_layers = nl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("en_in_load", 32'(en_v), 32'd0);
    @(negedge clk);
    chk("start_to_en_2cyc", 32'(en_v != 3'b000), 32'd1);
    if (disturb) begin
      repeat (2) @(negedge clk);
      start    = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 3'd1;
      cfg_data = 17'h1ffff;
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("final_memstartp", 32'(eif.memstartp), 32'(fin));
    chk("err_clear", 32'(err), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_layers = 4'd3; start = 1'b0;

    tbl[0] = {2'd0, 5'd28, 10'd0};
    tbl[1] = {2'd1, 5'd28, 10'd756};
    tbl[2] = {2'd2, 5'd0,  10'd0};
    tbl[3] = {2'd3, 5'd5,  10'd5};
    tbl[4] = {2'd0, 5'd14, 10'd195};
    tbl[5] = {2'd1, 5'd14, 10'd190};
    tbl[6] = {2'd2, 5'd7,  10'd48};
    tbl[7] = {2'd0, 5'd3,  10'd1023};

    vecs[0] = '{nl: 4'd3, disturb: 1'b0, exp_layers: 3, exp_final: BUF_B};
    vecs[1] = '{nl: 4'd3, disturb: 1'b1, exp_layers: 3, exp_final: BUF_B};
    vecs[2] = '{nl: 4'd2, disturb: 1'b0, exp_layers: 2, exp_final: BUF_A};
    vecs[3] = '{nl: 4'd1, disturb: 1'b0, exp_layers: 1, exp_final: BUF_B};
    vecs[4] = '{nl: 4'd4, disturb: 1'b0, exp_layers: 4, exp_final: BUF_A};
    vecs[5] = '{nl: 4'd0, disturb: 1'b0, exp_layers: 8, exp_final: BUF_A};
    vecs[6] = '{nl: 4'd9, disturb: 1'b0, exp_layers: 8, exp_final: BUF_A};

    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en_v), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_idx", 32'(layer_idx), 32'd0);
    chk("rst_memstartp", 32'(eif.memstartp), 32'(BUF_A));
    chk("rst_memstartzap", 32'(eif.memstartzap), 32'(BUF_B));
    chk("rst_matrix", 32'(eif.matrix), 32'd0);
    chk("rst_matrix2", 32'(eif.matrix2), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = tbl[i];
    end
    @(negedge clk);
    cfg_we = 1'b0;

    for (int v = 0; v < 7; v++)
      run_pass(vecs[v].nl, vecs[v].exp_layers, vecs[v].exp_final, vecs[v].disturb);

    // Reset in the middle of layer 1's RUN abandons the pass.
    push_expected(3);
    @(negedge clk);
    num_layers = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (eif.maxp_en) seen = 1'b1;
    end
    chk("reach_layer1", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_en", 32'(en_v), 32'd0);
    chk("midrst_idx", 32'(layer_idx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_memstartp", 32'(eif.memstartp), 32'(BUF_A));
    rst_n = 1'b1;
    sbq.delete();
    run_pass(4'd2, 2, BUF_A, 1'b0);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Watchdog: engine never stops, pass ends with err after 64 RUN cycles.
    stop_delay = 1000000;
    exp_len    = 64;
    push_expected(1);
    @(negedge clk);
    num_layers = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    k = 1;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    chk("tmo_done_cycle", 32'(k), 32'd66);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_en_low", 32'(en_v), 32'd0);
    @(negedge clk);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    stop_delay = 10;
    exp_len    = 10;
    run_pass(4'd1, 1, BUF_B, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
